// File: rtl/ad9363_rx_capture.sv
// rtl/ad9363_rx_capture.sv - armed snapshot capture of AD9363 RX I/Q samples with stream readout
//
// Purpose: once armed, waits for a trigger (immediate, or I >= trig_level) and stores
// len_eff consecutive qualified {Q,I} samples in block RAM. It then streams them out
// over a valid/ready port with sign-extended 16-bit rails.
// Ports:
//   clk, rst_n                      sample clock, asynchronous active-low reset
//   rx_status                       RX interface healthy; low while capturing -> err
//   adc_valid, adc_data_i0/q0       qualified two's-complement ADC samples
//   arm, abort                      single-cycle start / cancel pulses
//   trig_mode, trig_level           0 = immediate, 1 = signed level trigger on I
//   cap_len                         samples to capture (0 or > DEPTH means DEPTH)
//   m_valid, m_ready, m_data, m_last  readout stream
//   busy, done, err                 status (done/err sticky until the next arm)
module ad9363_rx_capture #(
  parameter int AW = 10,
  parameter int DW = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rx_status,
  input  logic          adc_valid,
  input  logic [DW-1:0] adc_data_i0,
  input  logic [DW-1:0] adc_data_q0,
  input  logic          arm,
  input  logic          abort,
  input  logic          trig_mode,
  input  logic [DW-1:0] trig_level,
  input  logic [AW:0]   cap_len,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [31:0]   m_data,
  output logic          m_last,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int          DEPTH   = 1 << AW;
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE     = (AW+1)'(1);
  localparam int          EXT     = 16 - DW;

  typedef enum logic [1:0] {IDLE, WAIT_TRIG, CAPTURE, READOUT} state_t;
  state_t state, state_nxt;

  logic [AW:0]     len_eff;
  logic [AW:0]     wr_addr;
  logic [AW:0]     wr_addr_inc;
  logic [AW:0]     rd_addr;
  logic [AW:0]     rd_addr_inc;

  logic [2*DW-1:0] mem [DEPTH];
  logic [2*DW-1:0] rd_data;
  logic            rd_pend;
  logic            rd_pend_last;

  // Two-entry prefetch FIFO between the RAM read port and the stream output.
  logic [2*DW-1:0] fifo_data [2];
  logic [1:0]      fifo_last;
  logic            fifo_wptr;
  logic            fifo_rptr;
  logic [1:0]      fifo_cnt;
  logic [2*DW-1:0] head;

  logic arm_go, wr_en, set_err, set_done;
  logic trig_hit, xfer, rd_issue, rd_clear;

  assign wr_addr_inc = wr_addr + ONE;
  assign rd_addr_inc = rd_addr + ONE;
  assign trig_hit    = adc_valid && ($signed(adc_data_i0) >= $signed(trig_level));
  assign xfer        = m_valid && m_ready;
  assign busy        = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // abort beats rx_status loss, which beats trigger/capture/readout progress.
  always_comb begin
    state_nxt = state;
    arm_go    = 1'b0;
    wr_en     = 1'b0;
    set_err   = 1'b0;
    set_done  = 1'b0;
    case (state)
      IDLE: begin
        if (arm) begin
          state_nxt = WAIT_TRIG;
          arm_go    = 1'b1;
        end
      end
      WAIT_TRIG: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (!rx_status) begin
          state_nxt = IDLE;
          set_err   = 1'b1;
        end else if (!trig_mode) begin
          state_nxt = CAPTURE;
        end else if (trig_hit) begin
          // The triggering sample is word 0; a length of 1 finishes right here.
          wr_en     = 1'b1;
          state_nxt = (wr_addr_inc == len_eff) ? READOUT : CAPTURE;
        end
      end
      CAPTURE: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (!rx_status) begin
          state_nxt = IDLE;
          set_err   = 1'b1;
        end else if (adc_valid) begin
          wr_en = 1'b1;
          if (wr_addr_inc == len_eff) state_nxt = READOUT;
        end
      end
      READOUT: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (xfer && m_last) begin
          state_nxt = IDLE;
          set_done  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_eff <= '0;
      wr_addr <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      if (arm_go) begin
        len_eff <= (cap_len == '0 || cap_len > DEPTH_W) ? DEPTH_W : cap_len;
        wr_addr <= '0;
        done    <= 1'b0;
        err     <= 1'b0;
      end else if (wr_en) begin
        wr_addr <= wr_addr_inc;
      end
      if (set_err)  err  <= 1'b1;
      if (set_done) done <= 1'b1;
    end
  end

  // Keep the read pipeline empty outside READOUT so every readout starts clean
  // and abort drops m_valid on the following cycle.
  assign rd_clear = (state != READOUT) || abort;

  // Issue a read whenever the FIFO plus the in-flight read will still fit after
  // this cycle's pop; this sustains one beat per cycle with m_ready high.
  assign rd_issue = !rd_clear && (rd_addr < len_eff) &&
                    (({1'b0, fifo_cnt} + {2'b0, rd_pend}) < (3'd2 + {2'b0, xfer}));

  always_ff @(posedge clk) begin
    if (wr_en)    mem[wr_addr[AW-1:0]] <= {adc_data_q0, adc_data_i0};
    if (rd_issue) rd_data <= mem[rd_addr[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (!rd_clear && rd_pend) fifo_data[fifo_wptr] <= rd_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr      <= '0;
      rd_pend      <= 1'b0;
      rd_pend_last <= 1'b0;
      fifo_last    <= '0;
      fifo_wptr    <= 1'b0;
      fifo_rptr    <= 1'b0;
      fifo_cnt     <= '0;
    end else if (rd_clear) begin
      rd_addr      <= '0;
      rd_pend      <= 1'b0;
      rd_pend_last <= 1'b0;
      fifo_last    <= '0;
      fifo_wptr    <= 1'b0;
      fifo_rptr    <= 1'b0;
      fifo_cnt     <= '0;
    end else begin
      rd_pend      <= rd_issue;
      rd_pend_last <= rd_issue && (rd_addr_inc == len_eff);
      if (rd_issue) rd_addr <= rd_addr_inc;
      if (rd_pend) begin
        fifo_last[fifo_wptr] <= rd_pend_last;
        fifo_wptr            <= ~fifo_wptr;
      end
      if (xfer) fifo_rptr <= ~fifo_rptr;
      fifo_cnt <= fifo_cnt + {1'b0, rd_pend} - {1'b0, xfer};
    end
  end

  assign head    = fifo_data[fifo_rptr];
  assign m_valid = (fifo_cnt != 2'd0);
  assign m_last  = m_valid && fifo_last[fifo_rptr];
  assign m_data  = m_valid ? {{EXT{head[2*DW-1]}}, head[2*DW-1:DW],
                              {EXT{head[DW-1]}},   head[DW-1:0]} : 32'd0;

endmodule

// File: tb/tb_ad9363_rx_capture.sv
// tb/tb_ad9363_rx_capture.sv - directed self-checking bench for ad9363_rx_capture
module tb_ad9363_rx_capture;

  localparam int AW    = 10;
  localparam int DW    = 12;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rx_status;
  logic          adc_valid;
  logic [DW-1:0] adc_data_i0;
  logic [DW-1:0] adc_data_q0;
  logic          arm;
  logic          abort;
  logic          trig_mode;
  logic [DW-1:0] trig_level;
  logic [AW:0]   cap_len;
  logic          m_valid;
  logic          m_ready;
  logic [31:0]   m_data;
  logic          m_last;
  logic          busy;
  logic          done;
  logic          err;

  always #5 clk = ~clk;

  ad9363_rx_capture #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .rx_status(rx_status), .adc_valid(adc_valid),
    .adc_data_i0(adc_data_i0), .adc_data_q0(adc_data_q0), .arm(arm), .abort(abort),
    .trig_mode(trig_mode), .trig_level(trig_level), .cap_len(cap_len),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .done(done), .err(err)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] got_d[$];
  logic        got_l[$];
  int          got_c[$];
  int          stable_bad;
  int          timed_out;

  function automatic logic [31:0] ext(input logic [11:0] i, input logic [11:0] q);
    return {{4{q[11]}}, q, {4{i[11]}}, i};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp(input logic [11:0] i, input logic [11:0] q, input logic v);
    adc_data_i0 = i;
    adc_data_q0 = q;
    adc_valid   = v;
    tick();
  endtask

  task automatic arm_cap(input logic mode, input logic [11:0] level, input logic [AW:0] len);
    trig_mode  = mode;
    trig_level = level;
    cap_len    = len;
    adc_valid  = 1'b0;
    arm        = 1'b1;
    tick();
    arm        = 1'b0;
  endtask

  // Drives m_ready (always high, or the repeating 1,0,0,1 pattern) and records
  // every handshake until m_last transfers or max_beats beats have been taken.
  task automatic collect(input int max_beats, input bit bp);
    int          cyc;
    bit          stalled;
    bit          fin;
    logic [31:0] prev;
    got_d.delete();
    got_l.delete();
    got_c.delete();
    cyc        = 0;
    stalled    = 1'b0;
    fin        = 1'b0;
    prev       = '0;
    stable_bad = 0;
    timed_out  = 0;
    while (!fin) begin
      m_ready = bp ? ((cyc % 4) == 0 || (cyc % 4) == 3) : 1'b1;
      if (stalled && (!m_valid || m_data !== prev)) stable_bad++;
      if (m_valid && m_ready) begin
        got_d.push_back(m_data);
        got_l.push_back(m_last);
        got_c.push_back(cyc);
      end
      stalled = m_valid && !m_ready;
      prev    = m_data;
      tick();
      cyc++;
      if (got_d.size() > 0 && (got_l[$] || got_d.size() == max_beats)) fin = 1'b1;
      if (cyc > 5000) begin
        timed_out = 1;
        fin       = 1'b1;
      end
    end
    m_ready = 1'b0;
  endtask

  initial begin
    int bad;
    int nlast;
    rst_n       = 1'b0;
    rx_status   = 1'b1;
    adc_valid   = 1'b0;
    adc_data_i0 = '0;
    adc_data_q0 = '0;
    arm         = 1'b0;
    abort       = 1'b0;
    trig_mode   = 1'b0;
    trig_level  = '0;
    cap_len     = '0;
    m_ready     = 1'b0;
    tick();
    tick();
    check("rst_m_valid", 32'(m_valid), 0);
    check("rst_m_last",  32'(m_last), 0);
    check("rst_m_data",  m_data, 0);
    check("rst_busy",    32'(busy), 0);
    check("rst_done",    32'(done), 0);
    check("rst_err",     32'(err), 0);
    rst_n = 1'b1;
    tick();

    // 1: immediate trigger, 16-sample ramp, Q = -I
    arm_cap(1'b0, 12'd0, 11'd16);
    check("t1_busy_armed", 32'(busy), 1);
    smp(12'd0, 12'd0, 1'b0);
    for (int k = 0; k < 16; k++) smp(12'(k), 12'(-k), 1'b1);
    smp(12'd16, 12'(-16), 1'b1);
    adc_valid = 1'b0;
    collect(100, 1'b0);
    check("t1_timeout", 32'(timed_out), 0);
    check("t1_beats", 32'(got_d.size()), 16);
    if (got_d.size() == 16) begin
      for (int k = 0; k < 16; k++) begin
        check($sformatf("t1_data%0d", k), got_d[k], ext(12'(k), 12'(-k)));
        check($sformatf("t1_last%0d", k), 32'(got_l[k]), (k == 15) ? 1 : 0);
      end
      check("t1_no_bubble", 32'(got_c[15] - got_c[0]), 15);
    end
    check("t1_done", 32'(done), 1);
    check("t1_busy", 32'(busy), 0);
    check("t1_valid_drop", 32'(m_valid), 0);

    // 2: level trigger at 100 on an I ramp from -2048 in steps of 50
    arm_cap(1'b1, 12'd100, 11'd8);
    for (int n = 0; n < 53; n++) smp(12'(-2048 + 50 * n), 12'(n), 1'b1);
    adc_valid = 1'b0;
    collect(100, 1'b0);
    check("t2_timeout", 32'(timed_out), 0);
    check("t2_beats", 32'(got_d.size()), 8);
    if (got_d.size() == 8) begin
      check("t2_first_i", 32'(got_d[0][11:0]), 102);
      bad = 0;
      for (int k = 0; k < 8; k++)
        if (got_d[k] !== ext(12'(-2048 + 50 * (43 + k)), 12'(43 + k))) bad++;
      check("t2_data", 32'(bad), 0);
    end

    // 3: backpressure with m_ready 1,0,0,1
    arm_cap(1'b0, 12'd0, 11'd8);
    smp(12'd0, 12'd0, 1'b0);
    for (int k = 0; k < 8; k++) smp(12'(256 + k), 12'(2032 - k), 1'b1);
    adc_valid = 1'b0;
    collect(100, 1'b1);
    check("t3_timeout", 32'(timed_out), 0);
    check("t3_beats", 32'(got_d.size()), 8);
    if (got_d.size() == 8) begin
      bad = 0;
      for (int k = 0; k < 8; k++)
        if (got_d[k] !== ext(12'(256 + k), 12'(2032 - k))) bad++;
      check("t3_order", 32'(bad), 0);
    end
    check("t3_stable", 32'(stable_bad), 0);

    // 4: adc_valid every third cycle, cap_len 4 (junk on unqualified cycles)
    arm_cap(1'b0, 12'd0, 11'd4);
    smp(12'd0, 12'd0, 1'b0);
    for (int c = 0; c < 11; c++)
      smp((c % 3 == 2) ? 12'(512 + c) : 12'h7ff, 12'(c), (c % 3 == 2));
    check("t4_busy_mid", 32'(busy), 1);
    check("t4_no_valid_mid", 32'(m_valid), 0);
    smp(12'(512 + 11), 12'd11, 1'b1);
    smp(12'h7ff, 12'd0, 1'b0);
    smp(12'h7ff, 12'd0, 1'b0);
    check("t4_first_valid_2cyc", 32'(m_valid), 1);
    collect(100, 1'b0);
    check("t4_beats", 32'(got_d.size()), 4);
    if (got_d.size() == 4) begin
      bad = 0;
      for (int k = 0; k < 4; k++)
        if (got_d[k] !== ext(12'(512 + 3 * k + 2), 12'(3 * k + 2))) bad++;
      check("t4_data", 32'(bad), 0);
    end

    // 5a: rx_status lost during CAPTURE
    arm_cap(1'b0, 12'd0, 11'd8);
    check("t5_done_cleared", 32'(done), 0);
    smp(12'd0, 12'd0, 1'b0);
    for (int k = 0; k < 3; k++) smp(12'(k), 12'(k), 1'b1);
    rx_status = 1'b0;
    smp(12'd3, 12'd3, 1'b1);
    rx_status = 1'b1;
    check("t5_err", 32'(err), 1);
    check("t5_err_busy", 32'(busy), 0);
    check("t5_err_valid", 32'(m_valid), 0);
    smp(12'd0, 12'd0, 1'b0);
    smp(12'd0, 12'd0, 1'b0);
    check("t5_err_valid_later", 32'(m_valid), 0);

    // 5b: arm ignored while busy, then abort in READOUT
    arm_cap(1'b0, 12'd0, 11'd8);
    check("t5_err_cleared", 32'(err), 0);
    smp(12'd0, 12'd0, 1'b0);
    for (int k = 0; k < 8; k++) smp(12'(k), 12'(k), 1'b1);
    smp(12'd0, 12'd0, 1'b0);
    smp(12'd0, 12'd0, 1'b0);
    check("t5_ro_valid", 32'(m_valid), 1);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    check("t5_arm_ignored", 32'(busy), 1);
    check("t5_arm_ignored_valid", 32'(m_valid), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t5_abort_valid", 32'(m_valid), 0);
    check("t5_abort_busy", 32'(busy), 0);
    check("t5_abort_done", 32'(done), 0);

    // 6: cap_len 0 and 2**AW+5 both capture DEPTH samples
    for (int r = 0; r < 2; r++) begin
      arm_cap(1'b0, 12'd0, (r == 0) ? 11'd0 : 11'(DEPTH + 5));
      smp(12'd0, 12'd0, 1'b0);
      for (int n = 0; n < DEPTH + 3; n++) smp(12'(n), ~12'(n), 1'b1);
      adc_valid = 1'b0;
      collect(DEPTH + 10, 1'b0);
      check($sformatf("t6_timeout%0d", r), 32'(timed_out), 0);
      check($sformatf("t6_beats%0d", r), 32'(got_d.size()), DEPTH);
      bad   = 0;
      nlast = 0;
      for (int n = 0; n < got_d.size(); n++) begin
        if (got_d[n] !== ext(12'(n), ~12'(n))) bad++;
        if (got_l[n]) nlast++;
      end
      check($sformatf("t6_data%0d", r), 32'(bad), 0);
      check($sformatf("t6_nlast%0d", r), 32'(nlast), 1);
      check($sformatf("t6_done%0d", r), 32'(done), 1);
    end

    // 6: asynchronous reset in the middle of READOUT
    arm_cap(1'b0, 12'd0, 11'd16);
    smp(12'd0, 12'd0, 1'b0);
    for (int k = 0; k < 16; k++) smp(12'(k + 5), 12'(k), 1'b1);
    adc_valid = 1'b0;
    collect(5, 1'b0);
    check("t6_pre_rst_valid", 32'(m_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(m_valid), 0);
    check("t6_rst_last",  32'(m_last), 0);
    check("t6_rst_data",  m_data, 0);
    check("t6_rst_busy",  32'(busy), 0);
    check("t6_rst_done",  32'(done), 0);
    check("t6_rst_err",   32'(err), 0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
